// File: rtl/vlane_flagreduce.sv
// vlane_flagreduce: sequential reduction of a streamed flag vector.
// Handles VFPOP, VFFF1, VFFL1 (scalar result) and VFSETBF, VFSETIF,
// VFSETOF (new flag vector streamed out chunk by chunk).
//
// Ports:
//   clk, resetn        clock (rising edge), async active-high reset
//   op_valid/op        operation request, accepted only in IDLE (op_ready)
//   in_*               flag chunk stream in (flags, element mask, last)
//   out_*              result flag chunk stream out (set ops only)
//   scalar_valid       one-cycle completion pulse with scalar_result
//   busy               unit is not idle
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an op request
// RUN   | consuming flag chunks, producing out chunks for set ops
// DONE  | stream finished; wait for out stage to drain, pulse result
module vlane_flagreduce #(
  parameter int NUMLANES     = 8,
  parameter int LOG2NUMLANES = 3,
  parameter int WIDTH        = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                op_valid,
  input  logic [2:0]          op,
  output logic                op_ready,
  input  logic                in_valid,
  input  logic [NUMLANES-1:0] in_flags,
  input  logic [NUMLANES-1:0] in_mask,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  output logic [NUMLANES-1:0] out_flags,
  input  logic                out_ready,
  output logic                scalar_valid,
  output logic [WIDTH-1:0]    scalar_result,
  output logic                busy
);

  localparam int CIDXW = WIDTH - LOG2NUMLANES;

  localparam logic [2:0] OP_POP   = 3'd0;
  localparam logic [2:0] OP_FF1   = 3'd1;
  localparam logic [2:0] OP_FL1   = 3'd2;
  localparam logic [2:0] OP_SETBF = 3'd3;
  localparam logic [2:0] OP_SETIF = 3'd4;
  localparam logic [2:0] OP_SETOF = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_op;
  logic [CIDXW-1:0]        r_chunk_idx;
  logic [WIDTH-1:0]        r_count;
  logic [WIDTH-1:0]        r_first;
  logic [WIDTH-1:0]        r_last;
  logic                    r_found;
  logic                    r_out_valid;
  logic [NUMLANES-1:0]     r_out_flags;

  logic                    w_is_set;
  logic                    w_accept;
  logic                    w_finish;
  logic [NUMLANES-1:0]     w_f;
  logic                    w_any;
  logic [WIDTH-1:0]        w_pop;
  logic [LOG2NUMLANES-1:0] w_lo_idx;
  logic [LOG2NUMLANES-1:0] w_hi_idx;
  logic                    w_seen;
  logic [NUMLANES-1:0]     w_out;

  assign w_is_set = (r_op == OP_SETBF) | (r_op == OP_SETIF) | (r_op == OP_SETOF);
  assign w_f      = in_flags & in_mask;
  assign w_any    = |w_f;

  // Single registered output stage: a set op may take a chunk whenever the
  // stage is empty or is being emptied this cycle.
  assign in_ready = (r_state == S_RUN) & (~w_is_set | ~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  // Set ops may only complete once the last out chunk has been taken.
  assign w_finish = (r_state == S_DONE) & (~w_is_set | ~r_out_valid);

  assign op_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign out_valid    = r_out_valid;
  assign out_flags    = r_out_flags;
  assign scalar_valid = w_finish;

  // Per-chunk reduction: popcount, lowest/highest set lane, and the
  // set-op output where seen tracks "a set flag occurred earlier".
  always_comb begin
    w_pop    = '0;
    w_lo_idx = '0;
    w_hi_idx = '0;
    w_out    = '0;
    w_seen   = r_found;
    for (int i = 0; i < NUMLANES; i++) begin
      w_pop = w_pop + WIDTH'(w_f[i]);
      if (w_f[i]) w_hi_idx = LOG2NUMLANES'(i);
    end
    for (int i = NUMLANES - 1; i >= 0; i--) begin
      if (w_f[i]) w_lo_idx = LOG2NUMLANES'(i);
    end
    for (int i = 0; i < NUMLANES; i++) begin
      case (r_op)
        OP_SETBF: w_out[i] = in_mask[i] & ~w_seen & ~w_f[i];
        OP_SETIF: w_out[i] = in_mask[i] & ~w_seen;
        OP_SETOF: w_out[i] = w_f[i] & ~w_seen;
        default:  w_out[i] = 1'b0;
      endcase
      w_seen = w_seen | w_f[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (op_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && in_last) w_state_nxt = S_DONE;
      S_DONE:  if (w_finish) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    scalar_result = '0;
    if (w_finish) begin
      case (r_op)
        OP_POP:  scalar_result = r_count;
        OP_FF1:  scalar_result = r_found ? r_first : '1;
        OP_FL1:  scalar_result = r_found ? r_last : '1;
        default: scalar_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_chunk_idx <= '0;
      r_count     <= '0;
      r_first     <= '0;
      r_last      <= '0;
      r_found     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_flags <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE && op_valid) begin
        r_op        <= op;
        r_chunk_idx <= '0;
        r_count     <= '0;
        r_first     <= '0;
        r_last      <= '0;
        r_found     <= 1'b0;
      end

      if (w_accept) begin
        r_chunk_idx <= r_chunk_idx + CIDXW'(1);
        case (r_op)
          OP_POP: r_count <= r_count + w_pop;
          OP_FF1: begin
            if (!r_found && w_any) begin
              r_first <= {r_chunk_idx, w_lo_idx};
              r_found <= 1'b1;
            end
          end
          OP_FL1: begin
            if (w_any) begin
              r_last  <= {r_chunk_idx, w_hi_idx};
              r_found <= 1'b1;
            end
          end
          OP_SETBF, OP_SETIF, OP_SETOF: r_found <= r_found | w_any;
          default: ;
        endcase
      end

      // Refill takes priority over drain so a same-cycle handshake on both
      // sides keeps the stage full with the new chunk.
      if (w_accept && w_is_set) begin
        r_out_valid <= 1'b1;
        r_out_flags <= w_out;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vlane_flagreduce.sv
module tb_vlane_flagreduce;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic        op_ready;
  logic        in_valid;
  logic [7:0]  in_flags;
  logic [7:0]  in_mask;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_flags;
  logic        out_ready;
  logic        scalar_valid;
  logic [15:0] scalar_result;
  logic        busy;

  vlane_flagreduce #(.NUMLANES(8), .LOG2NUMLANES(3), .WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .in_valid(in_valid), .in_flags(in_flags), .in_mask(in_mask), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_flags(out_flags),
    .out_ready(out_ready), .scalar_valid(scalar_valid), .scalar_result(scalar_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // stimulus vector
  logic [7:0] fl[64];
  logic [7:0] mk[64];
  int         n;
  int         hold_rdy;
  bit         rnd_valid;
  bit         rnd_ready;

  // observations from the last run
  logic [7:0]  q_out[$];
  logic [15:0] res;
  int          sv_cyc, last_acc, last_out, stable_bad, ir_bad, acc_in_hold;
  bit          timed_out, post_idle_ok;

  // reference results
  logic [7:0]  exp_out[$];
  logic [15:0] exp_res;

  // Element-level reference: walk every element of the whole vector.
  task automatic model(input int opc);
    int   pop = 0, first = -1, last = -1;
    bit   seen = 0;
    logic [7:0] ch = 0;
    exp_out.delete();
    for (int e = 0; e < n * 8; e++) begin
      logic [7:0] fc, mc;
      bit a, fb, o;
      fc = fl[e / 8];
      mc = mk[e / 8];
      a  = mc[e % 8];
      fb = fc[e % 8] & a;
      o  = 0;
      if (opc == 3) o = a & !seen & !fb;
      if (opc == 4) o = a & !seen;
      if (opc == 5) o = fb & !seen;
      ch[e % 8] = o;
      if (e % 8 == 7 && opc >= 3 && opc <= 5) exp_out.push_back(ch);
      if (fb) begin
        pop++;
        if (first < 0) first = e;
        last = e;
        seen = 1;
      end
    end
    case (opc)
      0: exp_res = 16'(pop);
      1: exp_res = (first < 0) ? 16'hFFFF : 16'(first);
      2: exp_res = (last < 0) ? 16'hFFFF : 16'(last);
      default: exp_res = 16'h0;
    endcase
  endtask

  function automatic logic [63:0] pack_q(input logic [7:0] q[$]);
    logic [63:0] p = '0;
    for (int i = 0; i < q.size() && i < 8; i++) p = p | (64'(q[i]) << (8 * i));
    return p;
  endfunction

  // Drives one operation to completion and records what the DUT did.
  task automatic run_op(input int opc);
    int  idx = 0;
    bit  got = 0, prev_stalled = 0;
    logic [7:0] prev_flags = 0;
    q_out.delete();
    res = 0; sv_cyc = -1; last_acc = -1; last_out = -1;
    stable_bad = 0; ir_bad = 0; acc_in_hold = 0;
    timed_out = 0; post_idle_ok = 0;
    @(negedge clk);
    op_valid = 1; op = 3'(opc);
    @(posedge clk);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      op_valid = 0;
      if (idx < n && (!rnd_valid || $urandom_range(3) != 0)) begin
        in_valid = 1; in_flags = fl[idx]; in_mask = mk[idx]; in_last = (idx == n - 1);
      end else begin
        in_valid = 0; in_flags = 0; in_mask = 0; in_last = 0;
      end
      out_ready = (cyc < hold_rdy) ? 1'b0 : (rnd_ready ? 1'($urandom_range(1)) : 1'b1);
      #1;
      if (prev_stalled && (!out_valid || out_flags !== prev_flags)) stable_bad++;
      if (opc >= 3 && opc <= 5 && out_valid && !out_ready && in_ready) ir_bad++;
      if (in_valid && in_ready) begin
        idx++;
        last_acc = cyc;
        if (cyc < hold_rdy) acc_in_hold++;
      end
      if (out_valid && out_ready) begin
        q_out.push_back(out_flags);
        last_out = cyc;
      end
      if (scalar_valid) begin
        res = scalar_result; sv_cyc = cyc; got = 1;
      end
      prev_stalled = out_valid && !out_ready;
      prev_flags   = out_flags;
      @(posedge clk);
      if (got) break;
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    if (!got) timed_out = 1;
    else begin
      @(negedge clk);
      #1;
      post_idle_ok = !scalar_valid && !busy && op_ready;
    end
  endtask

  task automatic test_reset;
    resetn = 1; op_valid = 0; op = 0; in_valid = 0; in_flags = 0; in_mask = 0;
    in_last = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_flags, scalar_valid, scalar_result, in_ready, busy} !== 28'h0)
      $display("FAIL reset_outputs: got ov=%b of=%h sv=%b sr=%h ir=%b busy=%b, want all 0",
               out_valid, out_flags, scalar_valid, scalar_result, in_ready, busy);
    else passed++;
    resetn = 0;
    #1;
    checks++;
    if (op_ready !== 1'b1) $display("FAIL reset_op_ready: got %b want 1", op_ready);
    else passed++;
  endtask

  task automatic test_popcount;
    rnd_valid = 0; rnd_ready = 0; hold_rdy = 0;
    n = 2; fl[0] = 8'hF0; mk[0] = 8'hFF; fl[1] = 8'h0F; mk[1] = 8'h3F;
    run_op(0);
    checks++;
    if (timed_out || res !== 16'd8) $display("FAIL pop_result: got %0d (timeout=%b) want 8", res, timed_out);
    else passed++;
    checks++;
    if (sv_cyc - last_acc != 1) $display("FAIL pop_latency: got %0d cycles after last accept want 1", sv_cyc - last_acc);
    else passed++;
    checks++;
    if (!post_idle_ok) $display("FAIL pop_single_pulse: got post_idle_ok=0 want 1");
    else passed++;
  endtask

  task automatic test_ff1_fl1;
    logic [15:0] want[2];
    want[0] = 16'd10; want[1] = 16'd13;
    rnd_valid = 0; rnd_ready = 0; hold_rdy = 0;
    n = 2; fl[0] = 8'h00; mk[0] = 8'hFF; fl[1] = 8'h24; mk[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      run_op(k + 1);
      checks++;
      if (timed_out || res !== want[k]) $display("FAIL ff1_fl1_op%0d: got %0d want %0d", k + 1, res, want[k]);
      else passed++;
    end
  endtask

  task automatic test_not_found;
    rnd_valid = 0; rnd_ready = 0; hold_rdy = 0;
    n = 3; for (int i = 0; i < 3; i++) begin fl[i] = 8'h00; mk[i] = 8'hFF; end
    run_op(1);
    checks++;
    if (timed_out || res !== 16'hFFFF) $display("FAIL ff1_all_zero: got %h want ffff", res);
    else passed++;
    n = 1; fl[0] = 8'hFF; mk[0] = 8'h00;
    run_op(1);
    checks++;
    if (timed_out || res !== 16'hFFFF) $display("FAIL ff1_masked: got %h want ffff", res);
    else passed++;
    run_op(2);
    checks++;
    if (timed_out || res !== 16'hFFFF) $display("FAIL fl1_masked: got %h want ffff", res);
    else passed++;
  endtask

  task automatic test_setops;
    logic [15:0] want[3];
    want[0] = 16'h000F; want[1] = 16'h001F; want[2] = 16'h0010;
    rnd_valid = 0; rnd_ready = 0; hold_rdy = 0;
    n = 2; fl[0] = 8'h10; mk[0] = 8'hFF; fl[1] = 8'h01; mk[1] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      run_op(k + 3);
      checks++;
      if (timed_out || q_out.size() != 2 || pack_q(q_out) !== 64'(want[k]))
        $display("FAIL setop%0d_chunks: got %0d chunks %h want 2 chunks %h",
                 k + 3, q_out.size(), pack_q(q_out), want[k]);
      else passed++;
      checks++;
      if (res !== 16'h0 || sv_cyc != last_out + 1 || !post_idle_ok)
        $display("FAIL setop%0d_done: got res=%h sv_cyc=%0d last_out=%0d idle=%b want 0/%0d/1",
                 k + 3, res, sv_cyc, last_out, post_idle_ok, last_out + 1);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    rnd_valid = 0; rnd_ready = 0; hold_rdy = 5;
    n = 4;
    fl[0] = 8'h00; fl[1] = 8'h00; fl[2] = 8'h08; fl[3] = 8'h40;
    for (int i = 0; i < 4; i++) mk[i] = 8'hFF;
    model(4);
    run_op(4);
    checks++;
    if (acc_in_hold != 1 || ir_bad != 0)
      $display("FAIL bp_in_ready: got accepts_in_stall=%0d ready_while_full=%0d want 1/0", acc_in_hold, ir_bad);
    else passed++;
    checks++;
    if (stable_bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", stable_bad);
    else passed++;
    checks++;
    if (timed_out || q_out.size() != 4 || pack_q(q_out) !== pack_q(exp_out))
      $display("FAIL bp_chunks: got %0d chunks %h want 4 chunks %h", q_out.size(), pack_q(q_out), pack_q(exp_out));
    else passed++;
    checks++;
    if (sv_cyc != last_out + 1 || !post_idle_ok)
      $display("FAIL bp_done: got sv_cyc=%0d last_out=%0d idle=%b want sv after last out", sv_cyc, last_out, post_idle_ok);
    else passed++;
    hold_rdy = 0;
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    op_valid = 1; op = 3'd4;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      op_valid = 0; in_valid = 1; in_flags = 8'h00; in_mask = 8'hFF; in_last = 0; out_ready = 1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #1;
    checks++;
    if (!busy || !out_valid || out_flags !== 8'hFF)
      $display("FAIL midrun_pre: got busy=%b ov=%b of=%h want 1/1/ff", busy, out_valid, out_flags);
    else passed++;
    resetn = 1;
    #1;
    checks++;
    if ({out_valid, out_flags, scalar_valid, scalar_result, in_ready, busy} !== 28'h0)
      $display("FAIL midrun_reset_outputs: got ov=%b of=%h sv=%b sr=%h ir=%b busy=%b want all 0",
               out_valid, out_flags, scalar_valid, scalar_result, in_ready, busy);
    else passed++;
    @(negedge clk);
    resetn = 0; out_ready = 1;
    #1;
    checks++;
    if (!op_ready || busy) $display("FAIL midrun_release: got op_ready=%b busy=%b want 1/0", op_ready, busy);
    else passed++;
    rnd_valid = 0; rnd_ready = 0; hold_rdy = 0;
    n = 2; fl[0] = 8'hA5; mk[0] = 8'hFF; fl[1] = 8'h81; mk[1] = 8'h7F;
    run_op(0);
    checks++;
    if (timed_out || res !== 16'd5) $display("FAIL midrun_fresh_pop: got %0d want 5", res);
    else passed++;
  endtask

  task automatic test_random;
    rnd_valid = 1; rnd_ready = 1; hold_rdy = 0;
    for (int it = 0; it < 40; it++) begin
      int opc;
      opc = $urandom_range(7);
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) begin
        fl[i] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom & $urandom);
        mk[i] = ($urandom_range(4) == 0) ? 8'hFF : 8'($urandom);
      end
      model(opc);
      run_op(opc);
      checks++;
      if (timed_out || res !== exp_res)
        $display("FAIL rand%0d_op%0d_result: got %h (timeout=%b) want %h", it, opc, res, timed_out, exp_res);
      else passed++;
      checks++;
      if (q_out.size() != exp_out.size() || pack_q(q_out) !== pack_q(exp_out))
        $display("FAIL rand%0d_op%0d_chunks: got %0d chunks %h want %0d chunks %h",
                 it, opc, q_out.size(), pack_q(q_out), exp_out.size(), pack_q(exp_out));
      else passed++;
      checks++;
      if (!post_idle_ok || stable_bad != 0 || ir_bad != 0)
        $display("FAIL rand%0d_op%0d_protocol: got idle=%b unstable=%0d ready_while_full=%0d want 1/0/0",
                 it, opc, post_idle_ok, stable_bad, ir_bad);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_popcount;
    test_ff1_fl1;
    test_not_found;
    test_setops;
    test_backpressure;
    test_reset_midrun;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
